pito_mem_reader: RTL

Read-back engine for a pito BRAM port (imem or dmem), the reading counterpart of the testbench/host loader that writes program and data words through `imem_w_en/imem_addr/imem_data`. On a start pulse it walks an inclusive word-address range, issues one read per cycle to the memory's read port, and streams `{addr, data, last}` beats out over a valid/ready interface through a small FIFO. It sits beside `rv32_core` on the memory side and is used for post-run memory dumps and scoreboarding without hierarchical peeks.

---
 rtl/pito_mem_reader_pkg.sv | 8 +
 rtl/pito_sync_fifo.sv | 42 ++++
 rtl/pito_mem_reader.sv | 92 +++++++++
 3 files changed

// File: rtl/pito_mem_reader_pkg.sv
// pito_mem_reader_pkg: shared widths, memory word types and reader FSM states
package pito_mem_reader_pkg;
  localparam int PITO_ADDR_W = 12;
  localparam int PITO_DATA_W = 32;
  typedef logic [PITO_ADDR_W-1:0] rv32_dmem_addr_t;
  typedef logic [PITO_DATA_W-1:0] rv32_data_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} pito_mem_reader_state_e;
endpackage

// File: rtl/pito_sync_fifo.sv
// pito_sync_fifo: synchronous FIFO with occupancy count and head read straight from storage
module pito_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  assign w_push = i_push && (r_cnt != CW'(DEPTH));
  assign w_pop = i_pop && o_valid;
  assign o_valid = r_cnt != '0;
  assign o_count = r_cnt;
  assign o_data = r_mem[r_rp];
  // storage, pointers and count; storage cleared so the head reads zero after reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/pito_mem_reader.sv
// pito_mem_reader: walks an inclusive BRAM word range and streams {addr, data, last} beats
module pito_mem_reader
  import pito_mem_reader_pkg::*;
#(
  parameter int ADDR_W = PITO_ADDR_W,
  parameter int DATA_W = PITO_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr_from,
  input  logic [ADDR_W-1:0] i_addr_to,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_last
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = ADDR_W + DATA_W + 1;
  pito_mem_reader_state_e r_state, w_next;
  logic [ADDR_W-1:0] r_ptr, r_to, r_inf_addr;
  logic r_inflight, r_done, r_err;
  logic w_pop, w_drained;
  logic [CW-1:0] w_count;
  logic [BW-1:0] w_head;
  assign o_busy = r_state != IDLE;
  assign o_done = r_done;
  assign o_err = r_err;
  assign o_mem_addr = r_ptr;
  assign w_pop = o_m_valid && i_m_ready;
  assign w_drained = r_state == DRAIN && !r_inflight && !r_done && w_count == CW'(w_pop);
  assign {o_m_addr, o_m_data, o_m_last} = w_head;
  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state and read strobe; a read is issued only if its data is guaranteed a FIFO slot
  always_comb begin
    w_next = r_state;
    o_mem_rd_en = 1'b0;
    case (r_state)
      IDLE: w_next = (i_start && i_addr_to >= i_addr_from) ? ISSUE : IDLE;
      ISSUE: begin
        o_mem_rd_en = (w_count + CW'(r_inflight)) < CW'(FIFO_DEPTH);
        w_next = (o_mem_rd_en && r_ptr == r_to) ? DRAIN : ISSUE;
      end
      DRAIN: w_next = r_done ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  // range latch, read pointer (never stepped past addr_to), inflight tag and status pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
      r_to <= '0;
      r_inf_addr <= '0;
      r_inflight <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_err <= r_state == IDLE && i_start && i_addr_to < i_addr_from;
      r_done <= w_drained;
      r_inflight <= o_mem_rd_en;
      if (o_mem_rd_en) r_inf_addr <= r_ptr;
      if (r_state == IDLE && w_next == ISSUE) begin
        r_ptr <= i_addr_from;
        r_to <= i_addr_to;
      end else if (o_mem_rd_en && r_ptr != r_to) begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end
    end
  end
  pito_sync_fifo #(.W(BW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_inflight),
    .i_data  ({r_inf_addr, i_mem_rdata, r_inf_addr == r_to}),
    .i_pop   (i_m_ready),
    .o_data  (w_head),
    .o_valid (o_m_valid),
    .o_count (w_count)
  );
endmodule
